uart_csr_apb: RTL

- Parametrised APB4 slave implementing the UART control/status register file, with integrated TX and RX FIFOs and an interrupt block.
- Sits between the APB fabric and the UART serializer/deserializer, and drives their static configuration.
- Successor to the fixed 8-register map: configurable FIFO depths and character width, two new registers (INT_STAT at 0x20, RX_THRESH at 0x24), overflow detection and irq_o.

---
 rtl/uart_csr_apb.sv | 242 ++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_csr_apb.sv
// APB4 control/status register file for the UART: configuration registers,
// TX/RX character FIFOs with overflow tracking, and a registered interrupt.
module uart_csr_apb #(
  parameter int          ADDR_WIDTH    = 32,
  parameter int          DATA_WIDTH    = 32,
  parameter int          TX_DEPTH      = 16,
  parameter int          RX_DEPTH      = 16,
  parameter int          CHAR_BITS     = 8,
  parameter logic [31:0] CLK_DIV_RESET = 32'd868
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    psel_i,
  input  logic                    penable_i,
  input  logic [ADDR_WIDTH-1:0]   paddr_i,
  input  logic                    pwrite_i,
  input  logic [DATA_WIDTH-1:0]   pwdata_i,
  input  logic [DATA_WIDTH/8-1:0] pstrb_i,
  output logic [DATA_WIDTH-1:0]   prdata_o,
  output logic                    pready_o,
  output logic                    pslverr_o,
  output logic [CHAR_BITS-1:0]    tx_data_o,
  output logic                    tx_valid_o,
  input  logic                    tx_ready_i,
  input  logic [CHAR_BITS-1:0]    rx_data_i,
  input  logic                    rx_valid_i,
  output logic                    clk_en_o,
  output logic                    parity_en_o,
  output logic                    parity_type_o,
  output logic                    stop_bits_o,
  output logic [31:0]             clk_div_o,
  output logic                    irq_o
);

  localparam int TXC_W = $clog2(TX_DEPTH + 1);
  localparam int RXC_W = $clog2(RX_DEPTH + 1);
  localparam int TXP_W = $clog2(TX_DEPTH);
  localparam int RXP_W = $clog2(RX_DEPTH);

  logic                 clk_en_q, clk_en_d;
  logic [5:0]           cfg_q, cfg_d;
  logic [31:0]          clk_div_q, clk_div_d;
  logic [7:0]           rx_thresh_q, rx_thresh_d;
  logic                 rx_ovf_q, rx_ovf_d;
  logic                 tx_ovf_q, tx_ovf_d;
  logic                 irq_q, irq_d;

  logic [CHAR_BITS-1:0] tx_mem_q [TX_DEPTH];
  logic [CHAR_BITS-1:0] tx_mem_d [TX_DEPTH];
  logic [TXP_W-1:0]     tx_wptr_q, tx_wptr_d, tx_rptr_q, tx_rptr_d;
  logic [TXC_W-1:0]     tx_count_q, tx_count_d;

  logic [CHAR_BITS-1:0] rx_mem_q [RX_DEPTH];
  logic [CHAR_BITS-1:0] rx_mem_d [RX_DEPTH];
  logic [RXP_W-1:0]     rx_wptr_q, rx_wptr_d, rx_rptr_q, rx_rptr_d;
  logic [RXC_W-1:0]     rx_count_q, rx_count_d;

  logic                 access, wr_acc, rd_acc, bad_addr, reg_err, reg_wr;
  logic [3:0]           idx;
  logic                 tx_full, tx_empty, tx_pop, tx_push_req, tx_push, tx_ovf_evt, tx_flush;
  logic                 rx_full, rx_empty, rx_pop, rx_push_req, rx_push, rx_ovf_evt, rx_flush;
  logic                 rx_thr, w1c;
  logic [CHAR_BITS-1:0] tx_head, rx_head;
  logic [31:0]          rdata;
  logic                 unused_addr_bits;

  assign unused_addr_bits = ^paddr_i[ADDR_WIDTH-1:6];

  assign tx_full  = (tx_count_q == TXC_W'(TX_DEPTH));
  assign tx_empty = (tx_count_q == '0);
  assign rx_full  = (rx_count_q == RXC_W'(RX_DEPTH));
  assign rx_empty = (rx_count_q == '0);
  assign tx_head  = tx_empty ? '0 : tx_mem_q[tx_rptr_q];
  assign rx_head  = rx_empty ? '0 : rx_mem_q[rx_rptr_q];
  assign rx_thr   = (rx_thresh_q != 8'd0) && (32'(rx_count_q) >= 32'(rx_thresh_q));

  // Access decode; a rejected access has no side effect except a TX overflow flag.
  always_comb begin
    access   = psel_i & penable_i;
    wr_acc   = access & pwrite_i;
    rd_acc   = access & ~pwrite_i;
    idx      = paddr_i[5:2];
    bad_addr = (paddr_i[1:0] != 2'b00) || (idx > 4'd9);
    reg_err  = bad_addr
             | (pwrite_i & ((idx == 4'd3) | (idx == 4'd4) | (idx == 4'd6) | (idx == 4'd7)))
             | (~pwrite_i & (idx == 4'd5))
             | (~pwrite_i & (idx == 4'd6) & rx_empty);
    reg_wr   = wr_acc & ~reg_err;

    tx_pop      = tx_valid_o & tx_ready_i;
    tx_push_req = reg_wr & (idx == 4'd5) & pstrb_i[0];
    tx_flush    = reg_wr & (idx == 4'd0) & pstrb_i[0] & pwdata_i[1];
    tx_ovf_evt  = tx_push_req & tx_full & ~tx_pop & ~tx_flush;
    tx_push     = tx_push_req & ~tx_ovf_evt;

    rx_pop      = rd_acc & ~reg_err & (idx == 4'd6);
    rx_push_req = rx_valid_i & clk_en_q;
    rx_flush    = reg_wr & (idx == 4'd0) & pstrb_i[0] & pwdata_i[2];
    rx_ovf_evt  = rx_push_req & rx_full & ~rx_pop & ~rx_flush;
    rx_push     = rx_push_req & ~rx_ovf_evt;

    w1c = reg_wr & (idx == 4'd8) & pstrb_i[0];
  end

  always_comb begin
    clk_en_d    = clk_en_q;
    cfg_d       = cfg_q;
    clk_div_d   = clk_div_q;
    rx_thresh_d = rx_thresh_q;
    if (reg_wr) begin
      case (idx)
        4'd0: if (pstrb_i[0]) clk_en_d = pwdata_i[0];
        4'd1: if (pstrb_i[0]) cfg_d = pwdata_i[5:0];
        4'd2: begin
          for (int b = 0; b < 4; b++) begin
            if (pstrb_i[b]) clk_div_d[8*b +: 8] = pwdata_i[8*b +: 8];
          end
        end
        4'd9: if (pstrb_i[0]) rx_thresh_d = pwdata_i[7:0];
        default: ;
      endcase
    end

    // A new overflow on the same edge as its W1C keeps the flag set.
    rx_ovf_d = rx_ovf_q;
    tx_ovf_d = tx_ovf_q;
    if (w1c && pwdata_i[2]) rx_ovf_d = 1'b0;
    if (w1c && pwdata_i[3]) tx_ovf_d = 1'b0;
    if (rx_ovf_evt) rx_ovf_d = 1'b1;
    if (tx_ovf_evt) tx_ovf_d = 1'b1;

    irq_d = (rx_thr & cfg_q[3]) | (tx_empty & cfg_q[4]) | ((rx_ovf_q | tx_ovf_q) & cfg_q[5]);
  end

  always_comb begin
    tx_mem_d   = tx_mem_q;
    tx_wptr_d  = tx_wptr_q;
    tx_rptr_d  = tx_rptr_q;
    tx_count_d = tx_count_q;
    if (tx_flush) begin
      tx_wptr_d  = '0;
      tx_rptr_d  = '0;
      tx_count_d = '0;
    end else begin
      if (tx_push) begin
        tx_mem_d[tx_wptr_q] = pwdata_i[CHAR_BITS-1:0];
        tx_wptr_d = (tx_wptr_q == TXP_W'(TX_DEPTH - 1)) ? '0 : tx_wptr_q + TXP_W'(1);
      end
      if (tx_pop) begin
        tx_rptr_d = (tx_rptr_q == TXP_W'(TX_DEPTH - 1)) ? '0 : tx_rptr_q + TXP_W'(1);
      end
      tx_count_d = tx_count_q + TXC_W'(tx_push) - TXC_W'(tx_pop);
    end
  end

  always_comb begin
    rx_mem_d   = rx_mem_q;
    rx_wptr_d  = rx_wptr_q;
    rx_rptr_d  = rx_rptr_q;
    rx_count_d = rx_count_q;
    if (rx_flush) begin
      rx_wptr_d  = '0;
      rx_rptr_d  = '0;
      rx_count_d = '0;
    end else begin
      if (rx_push) begin
        rx_mem_d[rx_wptr_q] = rx_data_i;
        rx_wptr_d = (rx_wptr_q == RXP_W'(RX_DEPTH - 1)) ? '0 : rx_wptr_q + RXP_W'(1);
      end
      if (rx_pop) begin
        rx_rptr_d = (rx_rptr_q == RXP_W'(RX_DEPTH - 1)) ? '0 : rx_rptr_q + RXP_W'(1);
      end
      rx_count_d = rx_count_q + RXC_W'(rx_push) - RXC_W'(rx_pop);
    end
  end

  always_comb begin
    rdata = '0;
    if (rd_acc && !reg_err) begin
      case (idx)
        4'd0:       rdata = {31'd0, clk_en_q};
        4'd1:       rdata = {26'd0, cfg_q};
        4'd2:       rdata = clk_div_q;
        4'd3:       rdata = 32'(tx_count_q);
        4'd4:       rdata = 32'(rx_count_q);
        4'd6, 4'd7: rdata = 32'(rx_head);
        4'd8:       rdata = {28'd0, tx_ovf_q, rx_ovf_q, tx_empty, rx_thr};
        4'd9:       rdata = {24'd0, rx_thresh_q};
        default:    rdata = '0;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      clk_en_q    <= 1'b0;
      cfg_q       <= '0;
      clk_div_q   <= CLK_DIV_RESET;
      rx_thresh_q <= '0;
      rx_ovf_q    <= 1'b0;
      tx_ovf_q    <= 1'b0;
      irq_q       <= 1'b0;
      tx_mem_q    <= '{default: '0};
      tx_wptr_q   <= '0;
      tx_rptr_q   <= '0;
      tx_count_q  <= '0;
      rx_mem_q    <= '{default: '0};
      rx_wptr_q   <= '0;
      rx_rptr_q   <= '0;
      rx_count_q  <= '0;
    end else begin
      clk_en_q    <= clk_en_d;
      cfg_q       <= cfg_d;
      clk_div_q   <= clk_div_d;
      rx_thresh_q <= rx_thresh_d;
      rx_ovf_q    <= rx_ovf_d;
      tx_ovf_q    <= tx_ovf_d;
      irq_q       <= irq_d;
      tx_mem_q    <= tx_mem_d;
      tx_wptr_q   <= tx_wptr_d;
      tx_rptr_q   <= tx_rptr_d;
      tx_count_q  <= tx_count_d;
      rx_mem_q    <= rx_mem_d;
      rx_wptr_q   <= rx_wptr_d;
      rx_rptr_q   <= rx_rptr_d;
      rx_count_q  <= rx_count_d;
    end
  end

  assign prdata_o      = DATA_WIDTH'(rdata);
  assign pready_o      = 1'b1;
  assign pslverr_o     = access & (reg_err | tx_ovf_evt);
  assign tx_valid_o    = clk_en_q & ~tx_empty;
  assign tx_data_o     = tx_head;
  assign clk_en_o      = clk_en_q;
  assign parity_en_o   = cfg_q[0];
  assign parity_type_o = cfg_q[1];
  assign stop_bits_o   = cfg_q[2];
  assign clk_div_o     = clk_div_q;
  assign irq_o         = irq_q;

endmodule
